// File: rtl/conv_window_if.sv
// Pixel-in / window-out stream bundle for conv_window_gen.
// master feeds pixels and drains windows; slave is the window generator.
interface conv_window_if #(
    parameter int DATA_W = 9,
    parameter int K      = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    in_sof;
    logic                    out_valid;
    logic                    out_ready;
    logic [K*K*DATA_W-1:0]   out_data;
    logic                    out_last;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_window_gen.sv
// K x K sliding-window generator over a raster pixel stream.
// K-1 circular line buffers share one write pointer; a window leaves one cycle after its last pixel.
module conv_window_gen #(
    parameter int DATA_W = 9,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input logic          clk,
    input logic          rst_n,
    conv_window_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LAST_C = (K - 1) + ((IMG_W - K) / STRIDE) * STRIDE;
    localparam int LAST_R = (K - 1) + ((IMG_H - K) / STRIDE) * STRIDE;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [CW-1:0] wptr_q, wptr_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          accept, hit, at_last;

    logic [DATA_W-1:0] win_q  [K][K];
    logic [DATA_W-1:0] win_d  [K][K];
    logic [DATA_W-1:0] lb_mem [K-1][IMG_W];
    logic [DATA_W-1:0] lb_tap [K-1];

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    // sof overrides the counters so a new frame can start anywhere
    assign cur_col = bus.in_sof ? '0 : col_q;
    assign cur_row = bus.in_sof ? '0 : row_q;

    assign hit = (cur_col >= CW'(K - 1))
              && (cur_row >= RW'(K - 1))
              && (((cur_col - CW'(K - 1)) % CW'(STRIDE)) == '0)
              && (((cur_row - RW'(K - 1)) % RW'(STRIDE)) == '0);

    assign at_last = (cur_col == CW'(LAST_C))
                  && (cur_row == RW'(LAST_R));

    always_comb begin
        for (int j = 0; j < K - 1; j++) begin
            lb_tap[j] = lb_mem[j][wptr_q];
        end
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        wptr_d = wptr_q;
        if (accept) begin
            wptr_d = (wptr_q == CW'(IMG_W - 1)) ? '0 : wptr_q + 1'b1;
            if (cur_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q && !bus.out_ready;
        out_last_d  = out_last_q && !bus.out_ready;
        if (accept) begin
            out_valid_d = hit;
            out_last_d  = hit && at_last;
        end
    end

    // newest column enters at c=K-1; row K-1 is the live pixel
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < K - 1; r++) begin
                win_d[r][K-1] = lb_tap[K-2-r];
            end
            win_d[K-1][K-1] = bus.in_data;
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                bus.out_data[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            wptr_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            wptr_q      <= wptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mem[0][wptr_q] <= bus.in_data;
            for (int j = 1; j < K - 1; j++) begin
                lb_mem[j][wptr_q] <= lb_tap[j-1];
            end
        end
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Parametrised sliding-window generator for the conv datapath. It accepts a raster-scan pixel stream through a valid/ready handshake and buffers K-1 image lines internally. It emits a K x K window for every valid-convolution position, with configurable stride, and feeds the MAC array. It generalises the fixed 3-row x 32-column shift heap with runtime frame control, row/column tracking, stride decimation and backpressure.

Parameters:
DATA_W, 9, pixel width in bits
IMG_W, 32, image width in pixels (>= K)
IMG_H, 32, image height in lines (>= K)
K, 3, kernel size; odd, 3..7
STRIDE, 1, window stride in both dimensions; 1 or 2

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  pixel valid
in_ready  out  1  block can accept a pixel
in_data  in  DATA_W  pixel value
in_sof  in  1  start of frame; qualifies the pixel as position (0,0)
out_valid  out  1  window valid
out_ready  in  1  downstream accepts the window
out_data  out  K*K*DATA_W  window; element r*K+c at bits [(r*K+c)*DATA_W +: DATA_W]; r=0 is the oldest row, c=0 the oldest column
out_last  out  1  marks the final window of a frame

Behaviour:
- Reset: rst_n sampled low on clk sets out_valid=0, out_last=0, out_data=0 (window regs cleared), col=0, row=0.
  - Line-buffer RAM/regs are not reset.
  - Reset mid-frame abandons the frame; the next accepted pixel is treated as (0,0).
- Accept: pixel accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational). No other state changes without accept.
- Storage: K-1 line buffers, each IMG_W deep, chained.
  - On accept, line buffer 0 takes in_data; line buffer j takes the output of buffer j-1.
  - Each buffer tap is the pixel from exactly IMG_W accepts earlier.
- Window regs: K x K registers. On accept, each row shifts one column toward c=0.
  - Column c=K-1 loads: row K-1 = in_data; row K-2 = lb0 tap; ... row 0 = lb(K-2) tap.
- Counters: col 0..IMG_W-1, row 0..IMG_H-1, advanced on accept.
  - col wraps to 0 and increments row; at (IMG_W-1, IMG_H-1) both wrap to 0.
  - in_sof on an accepted pixel forces that pixel to be (0,0) regardless of the counters; the next pixel is (1,0).
- Window valid condition for the accepted pixel at (col,row):
  - col >= K-1 and row >= K-1,
  - (col-(K-1)) mod STRIDE == 0,
  - (row-(K-1)) mod STRIDE == 0.
- Latency: 1 cycle. If the accepted pixel meets the condition, out_valid=1 next cycle and out_data holds the window whose bottom-right element is that pixel.
- out_last=1 with the window whose pixel is at (IMG_W-1, IMG_H-1), if that position is valid. Otherwise out_last marks the last valid position of the frame.
- Output handshake:
  - Accept without a valid window: out_valid goes to 0.
  - out_valid && !out_ready: out_data, out_valid and out_last hold; in_ready=0.
  - out_valid && out_ready with a simultaneous accept: the new window (or out_valid=0) replaces the old one with no bubble.
- Frame seam: windows spanning a frame boundary are suppressed by the row >= K-1 rule. Stale line-buffer contents are never emitted.

Test Plan:
- K=3, IMG_W=IMG_H=8, STRIDE=1, pixels 0..63 back-to-back, in_sof on pixel 0, out_ready=1 -> first out_valid the cycle after pixel 18 is accepted, window {0,1,2,8,9,10,16,17,18}; exactly 36 windows; out_last only on window {45,46,47,53,54,55,61,62,63}.
- Same stimulus with STRIDE=2 -> 9 windows at bottom-right pixels cols {2,4,6} x rows {2,4,6}; first {0,1,2,8,9,10,16,17,18}, second {2,3,4,10,11,12,18,19,20}; out_last on the window ending at pixel 54.
- Backpressure: STRIDE=1, out_ready toggled randomly (hold 0 for 3 cycles at window 1) -> in_ready=0 while stalled, out_data stable, window sequence identical to test 1, no loss or duplication.
- in_sof reasserted at pixel 20 of frame 1, then new frame 100..163 -> no window until the new row 2, col 2; first window {100,101,102,108,109,110,116,117,118}.
- rst_n low for 1 cycle after pixel 30 -> out_valid=0 and out_data=0 next cycle; restarted frame 0..63 reproduces test 1 exactly.
- K=5, IMG_W=IMG_H=8 -> 16 windows; first after pixel 36, containing rows 0..4 x cols 0..4 of the frame.
